alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Parametrised successor to the combinational ALU-control decoder. Decodes ALUOp/funct into an internal ALU code, then executes the operation. Single-cycle ops return after one cycle; multi-cycle unsigned multiply and divide run a shift-add or restoring iteration, one bit per cycle. Sits in the execute stage with valid/ready handshakes on both sides and one operation in flight.

Parameters:
WIDTH, 32, operand/result width in bits (minimum 4).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset; synchronous and active-low
in_valid  input  1  operation offered
in_ready  output  1  unit can accept an operation this cycle
alu_op  input  3  ALUOp from main control
funct  input  6  instruction funct field; used only when alu_op=3'b111
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result registers hold a completed result
out_ready  input  1  consumer accepts result
result  output  WIDTH  primary result; quotient for DIVU, low product for MULU
result_hi  output  WIDTH  high product (MULU), remainder (DIVU), else 0
zero  output  1  result==0
div_by_zero  output  1  DIVU with b==0
illegal  output  1  undecodable alu_op/funct; executed as ADD
busy  output  1  MUL or DIV iteration in progress

Behaviour:
- Decode: alu_op 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 NOR, 6 SLT. alu_op 7 uses funct: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 NOR, 6 SLT, 8 MULU, 9 DIVU.
- Any other funct under alu_op 7 executes as ADD with illegal=1. Decode is fully specified; no latched state.
- Arithmetic: ADD and SUB wrap modulo 2^WIDTH. SLT is a signed compare; result = {0..,1} if a<b, else 0. NOR = ~(a|b).
- MULU: unsigned 2*WIDTH product. DIVU: unsigned quotient and remainder.
- States:
  - IDLE: accepts an op and loads operands.
  - MUL / DIV: iteration count 0..WIDTH-1.
  - Output registers plus out_valid act as the hold stage.
- in_ready = rst_n & (state==IDLE) & (!out_valid | out_ready).
- Accept occurs when in_valid & in_ready at an edge.
- Single-cycle op accepted at edge k:
  - result, flags and out_valid=1 are registered at edge k.
  - Visible in cycle k+1 (latency 1).
  - Back-to-back accepts are allowed when out_ready=1: throughput 1/cycle.
- MULU/DIVU accepted at edge k:
  - busy=1 from cycle k+1.
  - WIDTH iterations; results and out_valid=1 registered at edge k+WIDTH; busy drops at the same edge.
  - in_ready stays 0 throughout.
- DIVU with b==0:
  - No iteration; completes at the accept edge (latency 1).
  - result = all ones, result_hi = a, div_by_zero=1, zero=0.
- Output hold: while out_valid & !out_ready, result, result_hi and all flags hold stable.
- out_valid clears on an edge with out_ready=1, unless a new single-cycle result loads on that same edge.
- Simultaneous completion and consume: a new accept on the same edge is allowed (in_ready includes out_ready).
- Flags (zero, div_by_zero, illegal) are registered with result and describe the op currently presented.
- Reset (rst_n=0 at an edge):
  - state IDLE; out_valid, busy, result, result_hi, zero, div_by_zero and illegal all clear to 0.
  - in_ready=0 while rst_n is low.
  - An in-flight MUL/DIV is aborted with no output produced.
- Ignored inputs: in_valid while in_ready=0 has no effect. out_ready while out_valid=0 is ignored.

Test Plan:
- WIDTH=8, alu_op=2, a=0xF0, b=0x20, out_ready=1 -> next cycle out_valid=1, result=0x10, zero=0, illegal=0. Back-to-back op alu_op=3, a=b=0x05 -> result=0x00, zero=1.
- WIDTH=8, alu_op=7, funct=6, a=0xFF, b=0x01 -> result=0x01. Swapped operands -> result=0x00. funct=0x3F -> ADD result, illegal=1.
- WIDTH=8, funct=8, a=0xFF, b=0xFF -> busy for 8 cycles, in_ready=0. Then result=0x01, result_hi=0xFE, out_valid asserted 8 cycles after accept.
- WIDTH=8, funct=9, a=200, b=7 -> after 8 cycles result=28, result_hi=4. Then b=0 -> next cycle result=0xFF, result_hi=200, div_by_zero=1.
- Backpressure: complete an ADD with out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Raise out_ready with in_valid=1 -> consume and new accept on the same edge.
- Reset mid-MULU (rst_n=0 at iteration 3 for 1 cycle) -> all outputs 0, no out_valid. A following ADD 1+1 -> result=2 with latency 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes ALUOp/funct, runs single-cycle logic ops in one cycle
// and unsigned multiply/divide as one-bit-per-cycle iterations behind valid/ready.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal,
    output logic             busy
);

    typedef enum logic [3:0] {
        C_AND, C_OR, C_ADD, C_SUB, C_XOR, C_NOR, C_SLT, C_MULU, C_DIVU
    } alu_code_e;

    typedef enum logic [1:0] {
        S_IDLE, S_MUL, S_DIV
    } state_e;

    state_e          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;
    logic             r_div_by_zero;
    logic             r_illegal;
    logic             r_out_valid;
    logic             r_busy;

    alu_code_e        w_code;
    logic             w_illegal;
    logic [WIDTH-1:0] w_res;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_div_sh;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    assign w_in_ready = rst_n & (r_state == S_IDLE) & (~r_out_valid | out_ready);
    assign w_accept   = in_valid & w_in_ready;
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign result_hi   = r_result_hi;
    assign zero        = r_zero;
    assign div_by_zero = r_div_by_zero;
    assign illegal     = r_illegal;
    assign busy        = r_busy;

    // Opcode decode; unknown funct falls back to ADD and raises illegal
    always_comb begin
        w_code    = C_ADD;
        w_illegal = 1'b0;
        if (alu_op != 3'b111) begin
            case (alu_op)
                3'd0:    w_code = C_AND;
                3'd1:    w_code = C_OR;
                3'd2:    w_code = C_ADD;
                3'd3:    w_code = C_SUB;
                3'd4:    w_code = C_XOR;
                3'd5:    w_code = C_NOR;
                3'd6:    w_code = C_SLT;
                default: w_code = C_ADD;
            endcase
        end else begin
            case (funct)
                6'd0:    w_code = C_AND;
                6'd1:    w_code = C_OR;
                6'd2:    w_code = C_ADD;
                6'd3:    w_code = C_SUB;
                6'd4:    w_code = C_XOR;
                6'd5:    w_code = C_NOR;
                6'd6:    w_code = C_SLT;
                6'd8:    w_code = C_MULU;
                6'd9:    w_code = C_DIVU;
                default: w_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_res = a + b;
        case (w_code)
            C_AND:   w_res = a & b;
            C_OR:    w_res = a | b;
            C_SUB:   w_res = a - b;
            C_XOR:   w_res = a ^ b;
            C_NOR:   w_res = ~(a | b);
            C_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: w_res = a + b;
        endcase
    end

    // Shift-add step: {hi,lo} holds partial product above the remaining multiplier bits
    always_comb begin
        w_mul_sum = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_op}) : {1'b0, r_hi};
        w_mul_hi  = w_mul_sum[WIDTH:1];
        w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end

    // Restoring step: hi is the partial remainder, lo shifts dividend out and quotient in
    always_comb begin
        w_div_sh   = {r_hi, r_lo[WIDTH-1]};
        w_div_diff = w_div_sh - {1'b0, r_op};
        w_div_ok   = ~w_div_diff[WIDTH];
        w_div_hi   = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
        w_div_lo   = {r_lo[WIDTH-2:0], w_div_ok};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_op          <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_result      <= '0;
            r_result_hi   <= '0;
            r_zero        <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_illegal     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_code == C_MULU) begin
                            r_op    <= b;
                            r_lo    <= a;
                            r_hi    <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_MUL;
                        end else if (w_code == C_DIVU && b != '0) begin
                            r_op    <= b;
                            r_lo    <= a;
                            r_hi    <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_DIV;
                        end else if (w_code == C_DIVU) begin
                            r_result      <= '1;
                            r_result_hi   <= a;
                            r_zero        <= 1'b0;
                            r_div_by_zero <= 1'b1;
                            r_illegal     <= 1'b0;
                            r_out_valid   <= 1'b1;
                        end else begin
                            r_result      <= w_res;
                            r_result_hi   <= '0;
                            r_zero        <= (w_res == '0);
                            r_div_by_zero <= 1'b0;
                            r_illegal     <= w_illegal;
                            r_out_valid   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_hi  <= w_mul_hi;
                    r_lo  <= w_mul_lo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result      <= w_mul_lo;
                        r_result_hi   <= w_mul_hi;
                        r_zero        <= (w_mul_lo == '0);
                        r_div_by_zero <= 1'b0;
                        r_illegal     <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                S_DIV: begin
                    r_hi  <= w_div_hi;
                    r_lo  <= w_div_lo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result      <= w_div_lo;
                        r_result_hi   <= w_div_hi;
                        r_zero        <= (w_div_lo == '0);
                        r_div_by_zero <= 1'b0;
                        r_illegal     <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit at WIDTH=8 with hand-computed expectations.
module tb_alu_exec_unit;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         div_by_zero;
    logic         illegal;
    logic         busy;

    int checks;
    int failures;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .result_hi(result_hi), .zero(zero), .div_by_zero(div_by_zero),
        .illegal(illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn,
                         input logic [W-1:0] va, input logic [W-1:0] vb);
        in_valid = v; alu_op = op; funct = fn; a = va; b = vb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1;
        drive(1'b0, 3'd0, 6'd0, 8'h00, 8'h00);
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (result !== 8'h00 || result_hi !== 8'h00) begin failures++; $display("FAIL rst_result got=%h/%h exp=00/00", result, result_hi); end
        checks++; if ({zero, div_by_zero, illegal, busy} !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {zero, div_by_zero, illegal, busy}); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        rst_n = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add_sub();
        out_ready = 1'b1;
        drive(1'b1, 3'd2, 6'd0, 8'hF0, 8'h20);
        tick();
        checks++; if (out_valid !== 1'b1 || result !== 8'h10) begin failures++; $display("FAIL add got=%b/%h exp=1/10", out_valid, result); end
        checks++; if (zero !== 1'b0 || illegal !== 1'b0 || result_hi !== 8'h00) begin failures++; $display("FAIL add_flags got z=%b il=%b hi=%h exp 0/0/00", zero, illegal, result_hi); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL add_b2b_ready got=%b exp=1", in_ready); end
        drive(1'b1, 3'd3, 6'd0, 8'h05, 8'h05);
        tick();
        checks++; if (out_valid !== 1'b1 || result !== 8'h00 || zero !== 1'b1) begin failures++; $display("FAIL sub_b2b got=%b/%h z=%b exp=1/00 z=1", out_valid, result, zero); end
        drive(1'b1, 3'd5, 6'd0, 8'h0F, 8'h30);
        tick();
        checks++; if (result !== 8'hC0 || zero !== 1'b0) begin failures++; $display("FAIL nor got=%h exp=c0", result); end
        drive(1'b1, 3'd4, 6'd0, 8'hFF, 8'h0F);
        tick();
        checks++; if (result !== 8'hF0) begin failures++; $display("FAIL xor got=%h exp=f0", result); end
        drive(1'b0, 3'd0, 6'd0, 8'h00, 8'h00);
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_slt_illegal();
        out_ready = 1'b1;
        drive(1'b1, 3'd7, 6'd6, 8'hFF, 8'h01);
        tick();
        checks++; if (result !== 8'h01 || illegal !== 1'b0) begin failures++; $display("FAIL slt_neg got=%h il=%b exp=01 il=0", result, illegal); end
        drive(1'b1, 3'd7, 6'd6, 8'h01, 8'hFF);
        tick();
        checks++; if (result !== 8'h00 || zero !== 1'b1) begin failures++; $display("FAIL slt_swap got=%h z=%b exp=00 z=1", result, zero); end
        drive(1'b1, 3'd7, 6'h3F, 8'h12, 8'h34);
        tick();
        checks++; if (result !== 8'h46 || illegal !== 1'b1) begin failures++; $display("FAIL illegal got=%h il=%b exp=46 il=1", result, illegal); end
        drive(1'b1, 3'd7, 6'd1, 8'h12, 8'h34);
        tick();
        checks++; if (result !== 8'h36 || illegal !== 1'b0) begin failures++; $display("FAIL funct_or got=%h il=%b exp=36 il=0", result, illegal); end
        drive(1'b0, 3'd0, 6'd0, 8'h00, 8'h00);
        tick();
    endtask

    task automatic test_mulu();
        out_ready = 1'b1;
        drive(1'b1, 3'd7, 6'd8, 8'hFF, 8'hFF);
        tick();
        drive(1'b0, 3'd2, 6'd0, 8'h01, 8'h01);
        for (int i = 1; i < 8; i++) begin
            checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL mul_busy cyc=%0d got b=%b r=%b v=%b exp 1/0/0", i, busy, in_ready, out_valid); end
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        tick();
        checks++; if (out_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mul_done got v=%b b=%b exp 1/0", out_valid, busy); end
        checks++; if (result !== 8'h01 || result_hi !== 8'hFE) begin failures++; $display("FAIL mul_val got=%h%h exp=fe01", result_hi, result); end
        tick();
    endtask

    task automatic test_divu();
        out_ready = 1'b1;
        drive(1'b1, 3'd7, 6'd9, 8'd200, 8'd7);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL div_busy cyc=%0d got b=%b v=%b exp 1/0", i, busy, out_valid); end
            tick();
        end
        tick();
        checks++; if (out_valid !== 1'b1 || result !== 8'd28 || result_hi !== 8'd4 || div_by_zero !== 1'b0) begin failures++; $display("FAIL div got v=%b q=%0d r=%0d dz=%b exp 1/28/4/0", out_valid, result, result_hi, div_by_zero); end
        drive(1'b1, 3'd7, 6'd9, 8'd200, 8'd0);
        tick();
        checks++; if (out_valid !== 1'b1 || result !== 8'hFF || result_hi !== 8'd200) begin failures++; $display("FAIL div0 got v=%b q=%h r=%0d exp 1/ff/200", out_valid, result, result_hi); end
        checks++; if (div_by_zero !== 1'b1 || zero !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL div0_flags got dz=%b z=%b b=%b exp 1/0/0", div_by_zero, zero, busy); end
        drive(1'b1, 3'd7, 6'd9, 8'd5, 8'd9);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (out_valid !== 1'b1 || result !== 8'd0 || result_hi !== 8'd5 || zero !== 1'b1) begin failures++; $display("FAIL div_small got q=%0d r=%0d z=%b exp 0/5/1", result, result_hi, zero); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 6'd0, 8'h03, 8'h04);
        tick();
        drive(1'b1, 3'd3, 6'd0, 8'h10, 8'h01);
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || result !== 8'h07 || in_ready !== 1'b0 || zero !== 1'b0) begin failures++; $display("FAIL hold cyc=%0d got v=%b res=%h rdy=%b exp 1/07/0", i, out_valid, result, in_ready); end
            tick();
        end
        out_ready = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || result !== 8'h0F) begin failures++; $display("FAIL consume_accept got v=%b res=%h exp 1/0f", out_valid, result); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL consume_clear got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        out_ready = 1'b1;
        drive(1'b1, 3'd7, 6'd8, 8'hFF, 8'hFF);
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        checks++; if ({out_valid, busy, zero, div_by_zero, illegal} !== 5'b00000 || result !== 8'h00 || result_hi !== 8'h00) begin failures++; $display("FAIL mid_rst got v=%b b=%b res=%h%h", out_valid, busy, result_hi, result); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", in_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort cyc=%0d got v=%b b=%b exp 0/0", i, out_valid, busy); end
        end
        drive(1'b1, 3'd2, 6'd0, 8'h01, 8'h01);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 8'h02) begin failures++; $display("FAIL post_rst_add got v=%b res=%h exp 1/02", out_valid, result); end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_add_sub();
        test_slt_illegal();
        test_mulu();
        test_divu();
        test_backpressure();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
